// File: rtl/sramc_psum_packer_pkg.sv
// sramc_psum_packer_pkg: SRAM C write-side geometry and packer FSM states
package sramc_psum_packer_pkg;
   localparam int OC_W    = 32;
   localparam int SRAMC_W = 128;
   localparam int SRAMC_N = SRAMC_W / OC_W;
   localparam int ADRC_W  = 12;
   localparam int CNT_W   = ADRC_W + $clog2(SRAMC_N) + 1;
   localparam int LANE_W  = $clog2(SRAMC_N);
   typedef enum logic [1:0] {S_IDLE, S_PACK, S_WRITE, S_DONE} state_t;
endpackage

// File: rtl/sramc_word_assembler.sv
// sramc_word_assembler: lane buffer, write mask and lane index for one SRAM C word
module sramc_word_assembler
   import sramc_psum_packer_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_clear,
   input  logic               i_load,
   input  logic [OC_W-1:0]    i_data,
   output logic [SRAMC_W-1:0] o_word,
   output logic [SRAMC_N-1:0] o_mask,
   output logic               o_last_lane
);
   logic [SRAMC_W-1:0] r_word;
   logic [SRAMC_N-1:0] r_mask;
   logic [LANE_W-1:0]  r_k;
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_word <= '0;
         r_mask <= '0;
         r_k    <= '0;
      end else if (i_load) begin
         r_word[r_k*OC_W +: OC_W] <= i_data;
         r_mask[r_k]              <= 1'b1;
         r_k                      <= r_k + 1'b1;
      end
   end
   assign o_word      = r_word;
   assign o_mask      = r_mask;
   assign o_last_lane = (r_k == LANE_W'(SRAMC_N - 1));
endmodule

// File: rtl/sramc_psum_packer.sv
// sramc_psum_packer: packs a psum stream into SRAM C words written from a programmed base
module sramc_psum_packer
   import sramc_psum_packer_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [ADRC_W-1:0]  i_base_addr,
   input  logic [CNT_W-1:0]   i_n_elems,
   input  logic               i_psum_valid,
   input  logic [OC_W-1:0]    i_psum_data,
   output logic               o_psum_ready,
   output logic               o_sramc_wren,
   output logic [ADRC_W-1:0]  o_sramc_addr,
   output logic [SRAMC_W-1:0] o_sramc_wdata,
   output logic [SRAMC_N-1:0] o_sramc_wmask,
   input  logic               i_sramc_gnt,
   output logic               o_busy,
   output logic               o_done
);
   state_t            r_state, w_next;
   logic [ADRC_W-1:0] r_addr;
   logic [CNT_W-1:0]  r_rem;
   logic              w_clear, w_load, w_last_lane;
   assign o_psum_ready = (r_state == S_PACK);
   assign o_sramc_wren = (r_state == S_WRITE);
   assign o_done       = (r_state == S_DONE);
   assign o_busy       = (r_state != S_IDLE);
   assign o_sramc_addr = r_addr;
   assign w_load       = o_psum_ready && i_psum_valid;
   sramc_word_assembler u_asm (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_clear     (w_clear),
      .i_load      (w_load),
      .i_data      (i_psum_data),
      .o_word      (o_sramc_wdata),
      .o_mask      (o_sramc_wmask),
      .o_last_lane (w_last_lane)
   );
   always_comb begin
      w_next  = r_state;
      w_clear = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_clear = i_start;
            w_next  = !i_start ? S_IDLE : (i_n_elems == '0) ? S_DONE : S_PACK;
         end
         S_PACK:  w_next = (w_load && (w_last_lane || r_rem == CNT_W'(1))) ? S_WRITE : S_PACK;
         S_WRITE: begin
            w_clear = i_sramc_gnt;
            w_next  = !i_sramc_gnt ? S_WRITE : (r_rem == '0) ? S_DONE : S_PACK;
         end
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_rem   <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && i_start) begin
            r_addr <= i_base_addr;
            r_rem  <= i_n_elems;
         end
         if (w_load) r_rem <= r_rem - 1'b1;
         if (o_sramc_wren && i_sramc_gnt) r_addr <= r_addr + 1'b1;
      end
   end
endmodule
